// File: rtl/betting_round_fsm_pkg.sv
// Package for the betting-round controller: pulls in the shared poker types
// and defines the controller's state encoding.
package betting_round_fsm_pkg;

`include "poker_types.svh"

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLINDS,
        S_SEEK,
        S_WAIT_ACT,
        S_APPLY,
        S_DONE
    } state_t;

endpackage

// File: rtl/betting_round_fsm_if.sv
// Player-facing bus of the betting-round controller: the action prompt and
// handshake, plus the one-cycle chip-transfer report.
interface betting_round_fsm_if
    import betting_round_fsm_pkg::*;
#(
    parameter int NUM_SEATS = 8,
    parameter int STACK_W   = MAX_STACK_W
);
    localparam int SEAT_W = $clog2(NUM_SEATS);

    logic               action_valid;
    action_t            action;
    logic [STACK_W-1:0] raise_to;
    logic               action_ready;
    logic [SEAT_W-1:0]  turn_seat;
    logic [STACK_W-1:0] to_call;
    logic               bet_valid;
    logic [SEAT_W-1:0]  bet_seat;
    logic [STACK_W-1:0] bet_amt;

    // Player / table side: supplies actions, observes prompts and transfers.
    modport master (
        output action_valid, action, raise_to,
        input  action_ready, turn_seat, to_call, bet_valid, bet_seat, bet_amt
    );

    // Controller side.
    modport slave (
        input  action_valid, action, raise_to,
        output action_ready, turn_seat, to_call, bet_valid, bet_seat, bet_amt
    );
endinterface

// File: rtl/betting_round_fsm_action_eval.sv
// betting_action_eval: purely combinational evaluation of one player action
// against the current call size, the seat's contribution and remaining stack.
// min_raise_to is the smallest non-all-in raise target the caller allows.
module betting_action_eval
    import betting_round_fsm_pkg::*;
#(
    parameter int STACK_W = MAX_STACK_W
) (
    input  action_t            action,
    input  logic [STACK_W-1:0] raise_to,
    input  logic [STACK_W-1:0] call_size,
    input  logic [STACK_W-1:0] contrib,
    input  logic [STACK_W-1:0] stack,
    input  logic [STACK_W:0]   min_raise_to,
    output logic [STACK_W-1:0] xfer,
    output logic               legal,
    output logic               goes_all_in
);
    logic [STACK_W-1:0] to_call;
    logic [STACK_W-1:0] need;
    logic               raise_ok;

    // Transfer amount and legality for the offered action.
    always_comb begin
        // NOTE: every output gets a value before the case so no path infers a latch.
        xfer     = '0;
        legal    = 1'b1;
        to_call  = (call_size > contrib) ? call_size - contrib : '0;
        need     = (raise_to > contrib) ? raise_to - contrib : '0;
        raise_ok = (raise_to > call_size) && (need <= stack) &&
                   (({1'b0, raise_to} >= min_raise_to) || (need == stack));
        case (action)
            CHECK_CALL: xfer = (to_call < stack) ? to_call : stack;
            BET_RAISE: begin
                legal = raise_ok;
                xfer  = raise_ok ? need : '0;
            end
            FOLD:      xfer = '0;
            default:   legal = 1'b0;
        endcase
        goes_all_in = legal && (action != FOLD) && (xfer == stack);
    end
endmodule

// File: rtl/poker_types.svh
// Shared poker type definitions: the per-turn action encoding and the widest
// chip amount any betting block is expected to carry.
`ifndef POKER_TYPES_SVH
`define POKER_TYPES_SVH

localparam int MAX_STACK_W = 16;

typedef enum logic [1:0] {
    CHECK_CALL = 2'd0,
    BET_RAISE  = 2'd1,
    FOLD       = 2'd2
} action_t;

`endif

// File: rtl/betting_round_fsm.sv
// betting_round_fsm: runs one betting round -- optional blinds, then prompts
// each live seat in turn until everyone still able to act has matched the
// current bet, or all but one seat has folded.
// Optional feature: define MIN_RAISE_EN to enforce a minimum raise increment
// of max(last raise, big blind) on any raise that is not all-in.
module betting_round_fsm
    import betting_round_fsm_pkg::*;
#(
    parameter int NUM_SEATS = 8,
    parameter int STACK_W   = MAX_STACK_W,
    localparam int SEAT_W   = $clog2(NUM_SEATS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_SEATS-1:0]              seat_mask,
    input  logic [NUM_SEATS-1:0][STACK_W-1:0] stacks,
    input  logic [SEAT_W-1:0]                 first_seat,
    input  logic [SEAT_W-1:0]                 sb_seat,
    input  logic [SEAT_W-1:0]                 bb_seat,
    input  logic                              post_blinds,
    input  logic [STACK_W-1:0]                sb_amt,
    input  logic [STACK_W-1:0]                bb_amt,
    betting_round_fsm_if.slave                bus,
    output logic [STACK_W-1:0]                call_size,
    output logic [STACK_W-1:0]                pot,
    output logic [NUM_SEATS-1:0]              folded,
    output logic [NUM_SEATS-1:0]              all_in,
    output logic                              round_done,
    output logic                              hand_over,
    output logic                              action_err
);
    localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(NUM_SEATS - 1);

    state_t                            state_q, state_d;
    logic [SEAT_W-1:0]                 cursor_q, cursor_d;
    logic [SEAT_W-1:0]                 scan_cnt_q, scan_cnt_d;
    logic                              blind_step_q, blind_step_d;
    logic [NUM_SEATS-1:0][STACK_W-1:0] stack_q, stack_d;
    logic [NUM_SEATS-1:0][STACK_W-1:0] contrib_q, contrib_d;
    logic [NUM_SEATS-1:0]              acted_q, acted_d;
    logic [NUM_SEATS-1:0]              folded_q, folded_d;
    logic [NUM_SEATS-1:0]              all_in_q, all_in_d;
    logic [STACK_W-1:0]                call_size_q, call_size_d;
    logic [STACK_W-1:0]                pot_q, pot_d;
    logic [SEAT_W-1:0]                 sb_seat_q, sb_seat_d;
    logic [SEAT_W-1:0]                 bb_seat_q, bb_seat_d;
    logic [STACK_W-1:0]                sb_amt_q, sb_amt_d;
    logic [STACK_W-1:0]                bb_amt_q, bb_amt_d;
    action_t                           action_q, action_d;
    logic [STACK_W-1:0]                raise_to_q, raise_to_d;
    logic [STACK_W-1:0]                xfer_q, xfer_d;
    logic                              xfer_all_in_q, xfer_all_in_d;
`ifdef MIN_RAISE_EN
    logic [STACK_W-1:0]                last_raise_q, last_raise_d;
`endif

    logic [STACK_W:0]   min_raise_to;
    logic [STACK_W-1:0] ev_xfer;
    logic               ev_legal;
    logic               ev_all_in;
    logic [SEAT_W-1:0]  blind_seat;
    logic [STACK_W-1:0] blind_amt;
    logic [STACK_W-1:0] blind_stack;
    logic [SEAT_W-1:0]  next_seat;
    logic               seat_eligible;

    // Smallest raise target that is legal without going all-in.
    always_comb begin
`ifdef MIN_RAISE_EN
        min_raise_to = {1'b0, call_size_q} +
                       {1'b0, (last_raise_q > bb_amt_q) ? last_raise_q : bb_amt_q};
`else
        min_raise_to = {1'b0, call_size_q} + 1'b1;
`endif
    end

    betting_action_eval #(.STACK_W(STACK_W)) u_eval (
        .action       (bus.action),
        .raise_to     (bus.raise_to),
        .call_size    (call_size_q),
        .contrib      (contrib_q[cursor_q]),
        .stack        (stack_q[cursor_q]),
        .min_raise_to (min_raise_to),
        .xfer         (ev_xfer),
        .legal        (ev_legal),
        .goes_all_in  (ev_all_in)
    );

    // Next-state, per-seat bookkeeping and all bus outputs.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        scan_cnt_d    = scan_cnt_q;
        blind_step_d  = blind_step_q;
        stack_d       = stack_q;
        contrib_d     = contrib_q;
        acted_d       = acted_q;
        folded_d      = folded_q;
        all_in_d      = all_in_q;
        call_size_d   = call_size_q;
        pot_d         = pot_q;
        sb_seat_d     = sb_seat_q;
        bb_seat_d     = bb_seat_q;
        sb_amt_d      = sb_amt_q;
        bb_amt_d      = bb_amt_q;
        action_d      = action_q;
        raise_to_d    = raise_to_q;
        xfer_d        = xfer_q;
        xfer_all_in_d = xfer_all_in_q;
`ifdef MIN_RAISE_EN
        last_raise_d  = last_raise_q;
`endif
        bus.action_ready = 1'b0;
        bus.bet_valid    = 1'b0;
        bus.bet_seat     = cursor_q;
        bus.bet_amt      = xfer_q;
        round_done       = 1'b0;
        hand_over        = 1'b0;
        action_err       = 1'b0;

        next_seat     = (cursor_q == LAST_SEAT) ? '0 : cursor_q + 1'b1;
        seat_eligible = !folded_q[cursor_q] && !all_in_q[cursor_q] &&
                        (!acted_q[cursor_q] || (contrib_q[cursor_q] < call_size_q));
        blind_seat    = blind_step_q ? bb_seat_q : sb_seat_q;
        blind_amt     = blind_step_q ? bb_amt_q : sb_amt_q;
        blind_stack   = stack_q[blind_seat];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stack_d      = stacks;
                    contrib_d    = '0;
                    acted_d      = '0;
                    all_in_d     = '0;
                    folded_d     = ~seat_mask;
                    pot_d        = '0;
                    call_size_d  = '0;
                    cursor_d     = first_seat;
                    scan_cnt_d   = '0;
                    blind_step_d = 1'b0;
                    sb_seat_d    = sb_seat;
                    bb_seat_d    = bb_seat;
                    sb_amt_d     = sb_amt;
                    bb_amt_d     = bb_amt;
`ifdef MIN_RAISE_EN
                    last_raise_d = '0;
`endif
                    state_d      = post_blinds ? S_BLINDS : S_SEEK;
                end
            end

            S_BLINDS: begin
                bus.bet_valid = 1'b1;
                bus.bet_seat  = blind_seat;
                bus.bet_amt   = (blind_amt < blind_stack) ? blind_amt : blind_stack;
                stack_d[blind_seat]   = blind_stack - bus.bet_amt;
                contrib_d[blind_seat] = contrib_q[blind_seat] + bus.bet_amt;
                pot_d                 = pot_q + bus.bet_amt;
                if (blind_amt >= blind_stack) all_in_d[blind_seat] = 1'b1;
                blind_step_d = ~blind_step_q;
                if (blind_step_q) begin
                    call_size_d = bb_amt_q;
`ifdef MIN_RAISE_EN
                    last_raise_d = bb_amt_q;
`endif
                    scan_cnt_d  = '0;
                    state_d     = S_SEEK;
                end
            end

            S_SEEK: begin
                if (seat_eligible) begin
                    state_d = S_WAIT_ACT;
                end else begin
                    cursor_d   = next_seat;
                    scan_cnt_d = scan_cnt_q + 1'b1;
                    if (scan_cnt_q == LAST_SEAT) state_d = S_DONE;
                end
            end

            S_WAIT_ACT: begin
                bus.action_ready = 1'b1;
                if (bus.action_valid) begin
                    if (!ev_legal) begin
                        action_err = 1'b1;
                    end else begin
                        action_d      = bus.action;
                        raise_to_d    = bus.raise_to;
                        xfer_d        = ev_xfer;
                        xfer_all_in_d = ev_all_in;
                        state_d       = S_APPLY;
                    end
                end
            end

            S_APPLY: begin
                bus.bet_valid       = (xfer_q != '0);
                stack_d[cursor_q]   = stack_q[cursor_q] - xfer_q;
                contrib_d[cursor_q] = contrib_q[cursor_q] + xfer_q;
                pot_d               = pot_q + xfer_q;
                if (xfer_all_in_q) all_in_d[cursor_q] = 1'b1;
                if (action_q == BET_RAISE) begin
                    acted_d     = '0;
                    call_size_d = raise_to_q;
`ifdef MIN_RAISE_EN
                    last_raise_d = raise_to_q - call_size_q;
`endif
                end
                acted_d[cursor_q] = 1'b1;
                cursor_d   = next_seat;
                scan_cnt_d = '0;
                state_d    = S_SEEK;
                if (action_q == FOLD) begin
                    folded_d[cursor_q] = 1'b1;
                    if ($onehot(~folded_d)) begin
                        hand_over = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end

            S_DONE: begin
                round_done = 1'b1;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A round being discarded by reset must not report any transfer or pulse.
        if (reset) begin
            bus.action_ready = 1'b0;
            bus.bet_valid    = 1'b0;
            round_done       = 1'b0;
            hand_over        = 1'b0;
            action_err       = 1'b0;
        end
    end

    // Prompt outputs and round status.
    always_comb begin
        bus.turn_seat = cursor_q;
        bus.to_call   = '0;
        if (state_q == S_WAIT_ACT && call_size_q > contrib_q[cursor_q])
            bus.to_call = call_size_q - contrib_q[cursor_q];
        call_size = call_size_q;
        pot       = pot_q;
        folded    = folded_q;
        all_in    = all_in_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: per-seat arrays are ordinary flops, not RAM, so they are reset with everything else.
            state_q       <= S_IDLE;
            cursor_q      <= '0;
            scan_cnt_q    <= '0;
            blind_step_q  <= 1'b0;
            stack_q       <= '0;
            contrib_q     <= '0;
            acted_q       <= '0;
            folded_q      <= '1;
            all_in_q      <= '0;
            call_size_q   <= '0;
            pot_q         <= '0;
            sb_seat_q     <= '0;
            bb_seat_q     <= '0;
            sb_amt_q      <= '0;
            bb_amt_q      <= '0;
            action_q      <= CHECK_CALL;
            raise_to_q    <= '0;
            xfer_q        <= '0;
            xfer_all_in_q <= 1'b0;
`ifdef MIN_RAISE_EN
            last_raise_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            scan_cnt_q    <= scan_cnt_d;
            blind_step_q  <= blind_step_d;
            stack_q       <= stack_d;
            contrib_q     <= contrib_d;
            acted_q       <= acted_d;
            folded_q      <= folded_d;
            all_in_q      <= all_in_d;
            call_size_q   <= call_size_d;
            pot_q         <= pot_d;
            sb_seat_q     <= sb_seat_d;
            bb_seat_q     <= bb_seat_d;
            sb_amt_q      <= sb_amt_d;
            bb_amt_q      <= bb_amt_d;
            action_q      <= action_d;
            raise_to_q    <= raise_to_d;
            xfer_q        <= xfer_d;
            xfer_all_in_q <= xfer_all_in_d;
`ifdef MIN_RAISE_EN
            last_raise_q  <= last_raise_d;
`endif
        end
    end
endmodule

// File: tb/tb_betting_round_fsm.sv
// Directed testbench for betting_round_fsm (8 seats, 16-bit chips).
module tb_betting_round_fsm;
    import betting_round_fsm_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [7:0]       seat_mask;
    logic [7:0][15:0] stacks;
    logic [2:0]       first_seat, sb_seat, bb_seat;
    logic             post_blinds;
    logic [15:0]      sb_amt, bb_amt;
    logic [15:0]      call_size, pot;
    logic [7:0]       folded, all_in;
    logic             round_done, hand_over, action_err;

    int checks = 0;
    int errors = 0;

    betting_round_fsm_if #(.NUM_SEATS(8), .STACK_W(16)) bus ();

    betting_round_fsm #(.NUM_SEATS(8), .STACK_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seat_mask   (seat_mask),
        .stacks      (stacks),
        .first_seat  (first_seat),
        .sb_seat     (sb_seat),
        .bb_seat     (bb_seat),
        .post_blinds (post_blinds),
        .sb_amt      (sb_amt),
        .bb_amt      (bb_amt),
        .bus         (bus),
        .call_size   (call_size),
        .pot         (pot),
        .folded      (folded),
        .all_in      (all_in),
        .round_done  (round_done),
        .hand_over   (hand_over),
        .action_err  (action_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Seats 0-2 seated, seat 0 first to act, blinds on seats 1 and 2 (1/2).
    task automatic begin_round(input logic blinds, input logic [15:0] s0,
                               input logic [15:0] s1, input logic [15:0] s2);
        seat_mask   = 8'h07;
        stacks      = '0;
        stacks[0]   = s0;
        stacks[1]   = s1;
        stacks[2]   = s2;
        first_seat  = 3'd0;
        sb_seat     = 3'd1;
        bb_seat     = 3'd2;
        post_blinds = blinds;
        sb_amt      = 16'd1;
        bb_amt      = 16'd2;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        #1;
    endtask

    task automatic wait_prompt(input string tag, input int seat, input int tc);
        int n = 0;
        while (!bus.action_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " ready"}, 32'(bus.action_ready), 1);
        check({tag, " turn_seat"}, 32'(bus.turn_seat), seat);
        check({tag, " to_call"}, 32'(bus.to_call), tc);
    endtask

    // Offer an accepted action, then check the transfer reported in APPLY.
    task automatic do_act(input string tag, input action_t a, input int raise,
                          input int seat, input logic exp_valid, input int exp_amt);
        bus.action_valid = 1'b1;
        bus.action       = a;
        bus.raise_to     = 16'(raise);
        #1;
        check({tag, " no err"}, 32'(action_err), 0);
        tick();
        bus.action_valid = 1'b0;
        #1;
        check({tag, " bet_valid"}, 32'(bus.bet_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({tag, " bet_seat"}, 32'(bus.bet_seat), seat);
            check({tag, " bet_amt"}, 32'(bus.bet_amt), exp_amt);
        end
    endtask

    // Run 20 cycles, counting end-of-round pulses and any further prompts.
    task automatic wait_done(input string tag, input int exp_ho);
        int rd = 0;
        int ho = 0;
        int rdy = 0;
        for (int i = 0; i < 20; i++) begin
            if (round_done) rd++;
            if (hand_over) ho++;
            if (bus.action_ready) rdy++;
            tick();
        end
        check({tag, " round_done pulses"}, 32'(rd), 1);
        check({tag, " hand_over pulses"}, 32'(ho), exp_ho);
        check({tag, " no further prompt"}, 32'(rdy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seat_mask = '0; stacks = '0;
        first_seat = '0; sb_seat = '0; bb_seat = '0; post_blinds = 1'b0;
        sb_amt = '0; bb_amt = '0;
        bus.action_valid = 1'b0; bus.action = CHECK_CALL; bus.raise_to = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset pot", 32'(pot), 0);
        check("reset call_size", 32'(call_size), 0);
        check("reset to_call", 32'(bus.to_call), 0);
        check("reset turn_seat", 32'(bus.turn_seat), 0);
        check("reset folded", 32'(folded), 32'hFF);
        check("reset all_in", 32'(all_in), 0);
        check("reset ready", 32'(bus.action_ready), 0);
        check("reset bet_valid", 32'(bus.bet_valid), 0);

        // Blinds, then everyone calls and the big blind checks.
        begin_round(1'b1, 16'd100, 16'd100, 16'd100);
        check("sb bet_valid", 32'(bus.bet_valid), 1);
        check("sb bet_seat", 32'(bus.bet_seat), 1);
        check("sb bet_amt", 32'(bus.bet_amt), 1);
        tick();
        check("bb bet_valid", 32'(bus.bet_valid), 1);
        check("bb bet_seat", 32'(bus.bet_seat), 2);
        check("bb bet_amt", 32'(bus.bet_amt), 2);
        tick();
        check("blinds pot", 32'(pot), 3);
        check("blinds call_size", 32'(call_size), 2);
        wait_prompt("A seat0", 0, 2);
        start = 1'b1; seat_mask = 8'hFF;
        tick();
        start = 1'b0; seat_mask = 8'h07;
        #1;
        check("start ignored folded", 32'(folded), 32'hF8);
        check("start ignored ready", 32'(bus.action_ready), 1);
        do_act("A seat0 call", CHECK_CALL, 0, 0, 1'b1, 2);
        wait_prompt("A seat1", 1, 1);
        do_act("A seat1 call", CHECK_CALL, 0, 1, 1'b1, 1);
        wait_prompt("A seat2", 2, 0);
        do_act("A seat2 check", CHECK_CALL, 0, 2, 1'b0, 0);
        wait_done("A", 0);
        check("A pot", 32'(pot), 6);

        // Seat 0 raises to 10, the blinds call.
        begin_round(1'b1, 16'd100, 16'd100, 16'd100);
        wait_prompt("B seat0", 0, 2);
        do_act("B seat0 raise", BET_RAISE, 10, 0, 1'b1, 10);
        wait_prompt("B seat1", 1, 9);
        do_act("B seat1 call", CHECK_CALL, 0, 1, 1'b1, 9);
        wait_prompt("B seat2", 2, 8);
        do_act("B seat2 call", CHECK_CALL, 0, 2, 1'b1, 8);
        wait_done("B", 0);
        check("B call_size", 32'(call_size), 10);
        check("B pot", 32'(pot), 30);

        // Short stack goes all-in on a call and is skipped afterwards.
        begin_round(1'b0, 16'd100, 16'd5, 16'd100);
        wait_prompt("C seat0", 0, 0);
        bus.action_valid = 1'b1; bus.action = BET_RAISE; bus.raise_to = 16'd200;
        #1;
        check("C raise over stack err", 32'(action_err), 1);
        tick();
        bus.action_valid = 1'b0;
        #1;
        check("C err holds ready", 32'(bus.action_ready), 1);
        check("C err holds seat", 32'(bus.turn_seat), 0);
        check("C err no bet", 32'(bus.bet_valid), 0);
        check("C err pot", 32'(pot), 0);
        bus.action_valid = 1'b1; bus.action = BET_RAISE; bus.raise_to = 16'd0;
        #1;
        check("C raise not above call err", 32'(action_err), 1);
        bus.action_valid = 1'b0;
        #1;
        do_act("C seat0 raise", BET_RAISE, 10, 0, 1'b1, 10);
        wait_prompt("C seat1", 1, 10);
        do_act("C seat1 allin call", CHECK_CALL, 0, 1, 1'b1, 5);
        wait_prompt("C seat2", 2, 10);
        check("C seat1 all_in", 32'(all_in), 32'h02);
        do_act("C seat2 raise", BET_RAISE, 20, 2, 1'b1, 20);
        wait_prompt("C seat0 again", 0, 10);
        do_act("C seat0 call", CHECK_CALL, 0, 0, 1'b1, 10);
        wait_done("C", 0);
        check("C pot", 32'(pot), 45);
        check("C call_size", 32'(call_size), 20);

        // Two folds end the hand.
        begin_round(1'b0, 16'd100, 16'd100, 16'd100);
        wait_prompt("D seat0", 0, 0);
        do_act("D seat0 fold", FOLD, 0, 0, 1'b0, 0);
        wait_prompt("D seat1", 1, 0);
        do_act("D seat1 fold", FOLD, 0, 1, 1'b0, 0);
        wait_done("D", 1);
        check("D folded", 32'(folded), 32'hFB);
        bus.action_valid = 1'b1; bus.action = FOLD;
        tick();
        bus.action_valid = 1'b0;
        #1;
        check("D idle action ignored", 32'(folded), 32'hFB);
        check("D idle no err", 32'(action_err), 0);

        // Minimum-raise rule: raise to 3 over a big blind of 2.
        begin_round(1'b1, 16'd100, 16'd100, 16'd100);
        wait_prompt("E seat0", 0, 2);
`ifdef MIN_RAISE_EN
        bus.action_valid = 1'b1; bus.action = BET_RAISE; bus.raise_to = 16'd3;
        #1;
        check("E min raise err", 32'(action_err), 1);
        tick();
        bus.action_valid = 1'b0;
        #1;
        check("E min raise call_size", 32'(call_size), 2);
        check("E min raise pot", 32'(pot), 3);
        check("E min raise ready", 32'(bus.action_ready), 1);
        do_act("E seat0 raise 4", BET_RAISE, 4, 0, 1'b1, 4);
`else
        do_act("E seat0 raise 3", BET_RAISE, 3, 0, 1'b1, 3);
`endif

        // Reset while a transfer is being reported discards the round.
        reset = 1'b1;
        #1;
        check("mid reset bet_valid", 32'(bus.bet_valid), 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid reset pot", 32'(pot), 0);
        check("mid reset call_size", 32'(call_size), 0);
        check("mid reset folded", 32'(folded), 32'hFF);
        check("mid reset all_in", 32'(all_in), 0);
        check("mid reset ready", 32'(bus.action_ready), 0);
        check("mid reset bet_valid after", 32'(bus.bet_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/betting_round_fsm.md
BETTING_ROUND_FSM -- requirements
Module: betting_round_fsm

Interface
REQ-001 SHALL have parameter NUM_SEATS, default 8, meaning the number of seats; SEAT_W = $clog2(NUM_SEATS).
REQ-002 SHALL have parameter STACK_W, default MAX_STACK_W, meaning the chip amount width.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high.
REQ-004 Port start, in, 1: pulse that begins a betting round (accepted in IDLE only).
REQ-005 Port seat_mask, in, NUM_SEATS: seated and not yet folded, latched on start.
REQ-006 Port stacks, in, NUM_SEATS x STACK_W: current stacks before this round's bets, latched on start.
REQ-007 Ports first_seat, sb_seat, bb_seat, in, SEAT_W each: first to act and blind seats, latched on start.
REQ-008 Ports post_blinds, in, 1, and sb_amt, bb_amt, in, STACK_W: blind posting, latched on start.
REQ-009 Ports action_valid, in, 1; action, in, action_t; raise_to, in, STACK_W: the turn seat's action and its target total contribution.
REQ-010 Ports action_ready, out, 1; turn_seat, out, SEAT_W; to_call, out, STACK_W: action prompt.
REQ-011 Ports bet_valid, out, 1; bet_seat, out, SEAT_W; bet_amt, out, STACK_W: one-cycle chip transfer, stack to pot.
REQ-012 Ports call_size, out, STACK_W; pot, out, STACK_W; folded, out, NUM_SEATS; all_in, out, NUM_SEATS.
REQ-013 Ports round_done, out, 1, and hand_over, out, 1 (single pulses); action_err, out, 1 (pulse on a rejected action).

Function
REQ-014 SHALL implement the states IDLE, BLINDS, SEEK, WAIT_ACT, APPLY and DONE.
REQ-015 On start: IDLE transitions to BLINDS if post_blinds is set, else to SEEK with the cursor at first_seat. Per-seat contribution, acted and all_in are cleared; folded = ~seat_mask.
REQ-016 In BLINDS, SHALL post sb in cycle 1 and bb in cycle 2, each as a bet_valid transfer clamped to the stack (marking all_in if clamped), then go to SEEK. call_size = bb_amt and last_raise = bb_amt.
REQ-017 In SEEK, SHALL examine one seat per cycle, with the cursor wrapping NUM_SEATS-1 to 0. A seat that is not folded and not all_in and that is (not acted, or contribution < call_size) stops the scan and the FSM enters WAIT_ACT. If a full lap finds none, the FSM enters DONE.
REQ-018 In WAIT_ACT, action_ready = 1, turn_seat = cursor and to_call = call_size - contribution (saturated at 0). An action is accepted on action_valid && action_ready and the FSM moves to APPLY.
REQ-019 CHECK_CALL SHALL transfer min(to_call, remaining stack). all_in is set if the remaining stack reaches 0. A zero transfer produces no bet_valid.
REQ-020 BET_RAISE SHALL be legal iff raise_to > call_size and raise_to - contribution <= remaining stack. A legal raise transfers raise_to - contribution, sets last_raise = raise_to - call_size, sets call_size = raise_to, and clears acted for all other seats.
REQ-021 An illegal BET_RAISE SHALL pulse action_err, cause no state change, and stay in WAIT_ACT.
REQ-022 FOLD SHALL set folded[seat]. If exactly one seat remains unfolded, the FSM pulses hand_over and enters DONE.
REQ-023 APPLY SHALL set acted[seat], update pot (pot += transfer, wrapping modulo 2^STACK_W), advance the cursor by 1, and return to SEEK. bet_valid is asserted in APPLY.
REQ-024 DONE SHALL pulse round_done for one cycle and return to IDLE. Pot, folded and all_in hold until the next start.
REQ-025 start SHALL be ignored outside IDLE. action_valid SHALL be ignored when action_ready is 0.

Reset
REQ-026 Reset SHALL return the FSM to IDLE, pulses to 0 and pot/call_size/to_call/turn_seat to 0, with folded = all ones and all_in = 0. Reset mid-round SHALL discard the round with no bet_valid issued.

Configuration
REQ-027 With MIN_RAISE_EN defined, BET_RAISE SHALL additionally require raise_to >= call_size + max(last_raise, bb_amt), unless the raise is all-in. Without the macro, any raise_to > call_size within the stack is legal.

Structure
REQ-028 action_t {CHECK_CALL, BET_RAISE, FOLD} and MAX_STACK_W SHALL live in poker_types.svh.
REQ-029 A combinational sub-module betting_action_eval SHALL compute transfer, legality and all-in for one action.

Verification
REQ-030 post_blinds, sb=1, bb=2, stacks 100, seats 0-2, button 0 -> bet_valid seat1 amount 1, then seat2 amount 2; pot=3; turn_seat=0; to_call=2.
REQ-031 All players call and the big blind checks -> three actions, pot=6, one round_done pulse, no hand_over.
REQ-032 Seat 0 raises to 10 after the blinds; seats 1 and 2 call -> call_size=10, pot=30, seat 2 re-prompted with to_call=8.
REQ-033 Seat 1 with stack 5 calls 10 -> bet_amt=5, all_in[1]=1, seat 1 skipped in SEEK thereafter.
REQ-034 Two folds in a 3-seat round -> hand_over and round_done pulse, DONE then IDLE.
REQ-035 With MIN_RAISE_EN, raise_to=3 over bb=2 -> action_err and state unchanged; without the macro -> accepted.
